serial_transmitter: RTL and testbench

SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

---
 rtl/serial_tx_pkg.sv | 21 ++
 rtl/tx_bit_counter.sv | 28 ++
 rtl/serial_transmitter.sv | 115 +++++++++++
 tb/tb_serial_transmitter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types for the serial transmitter: FSM state encoding and the parity helper.
// SERIAL_TX_PARITY_EN adds the PARITY state to the encoding.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
`ifdef SERIAL_TX_PARITY_EN
    StDone   = 2'd2,
    StParity = 2'd3
`else
    StDone   = 2'd2
`endif
  } tx_state_t;

  // Even parity over a zero-extended word; zero extension leaves the XOR unchanged.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Bit counter for the serial transmitter: counts shifted bits and flags the final one.
module tx_bit_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         enable,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         last
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CntW'(1);
    end
  end

  // High while the WIDTH-th bit is on the line, so its edge ends the data phase.
  assign last = (count == CntW'(WIDTH - 1));

endmodule

// File: rtl/serial_transmitter.sv
// MSB-first serial transmitter with valid/ready word intake and a one-clk txDone pulse.
// Define SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module serial_transmitter
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             peripheralClkEdge,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             dataValid,
  output logic             dataReady,
  output logic             serialDataOut,
  output logic             busy,
  output logic             txDone
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  tx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  cnt;
  logic             cnt_last;
  logic             accept;
  logic             shift_en;

  assign accept   = (state_q == StIdle) && dataValid;
  assign shift_en = (state_q == StShift) && peripheralClkEdge;

  tx_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .enable  (shift_en),
    .count   (cnt),
    .last    (cnt_last)
  );

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q;

  // Parity is taken from the captured word; the shift register is zero-filled by then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= even_parity(32'(parallelDataIn));
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    dataReady     = 1'b0;
    busy          = 1'b1;
    txDone        = 1'b0;
    serialDataOut = 1'b1;
    unique case (state_q)
      StIdle: begin
        dataReady = 1'b1;
        busy      = 1'b0;
        if (dataValid) begin
          shift_d = parallelDataIn;
          state_d = StShift;
        end
      end
      StShift: begin
        serialDataOut = shift_q[WIDTH-1];
        if (peripheralClkEdge) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (cnt_last) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      StParity: begin
        serialDataOut = parity_q;
        if (peripheralClkEdge) begin
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        txDone  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The counter never runs past WIDTH within a frame.
  assert property (@(posedge clk) disable iff (!reset_n) cnt <= CntW'(WIDTH));

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: directed vector table (WIDTH=4), hand sequences for reset
// and continuous strobes, and a randomized run (WIDTH=8) against a frame-queue model.
module tb_serial_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       pe4, dv4, ready4, ser4, busy4, done4;
  logic [3:0] word4;
  logic       pe8, dv8, ready8, ser8, busy8, done8;
  logic [7:0] word8;

  serial_transmitter #(.WIDTH(4)) dut4 (
    .clk               (clk),
    .reset_n           (reset_n),
    .peripheralClkEdge (pe4),
    .parallelDataIn    (word4),
    .dataValid         (dv4),
    .dataReady         (ready4),
    .serialDataOut     (ser4),
    .busy              (busy4),
    .txDone            (done4)
  );

  serial_transmitter #(.WIDTH(8)) dut8 (
    .clk               (clk),
    .reset_n           (reset_n),
    .peripheralClkEdge (pe8),
    .parallelDataIn    (word8),
    .dataValid         (dv8),
    .dataReady         (ready8),
    .serialDataOut     (ser8),
    .busy              (busy8),
    .txDone            (done8)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       dv;
    logic       pe;
    logic [3:0] word;
    logic       ready;
    logic       busy;
    logic       ser;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic dv, input logic pe, input logic [3:0] w,
                     input logic rdy, input logic bsy, input logic ser, input logic dn);
    vec_t v;
    v.dv = dv; v.pe = pe; v.word = w; v.ready = rdy; v.busy = bsy; v.ser = ser; v.done = dn;
    vecs.push_back(v);
  endtask

  // Frame model: queue of bits still to appear on the line, plus a pending-done flag.
  bit m_q[$];
  bit m_done;

  logic [7:0] exp_a5;
  int         done_seen;

  initial begin
    reset_n = 1'b1;
    {pe4, dv4, word4} = '0;
    {pe8, dv8, word8} = '0;
    #1 reset_n = 1'b0;
    #1;
    check("reset.ready4", ready4, 1);
    check("reset.busy4", busy4, 0);
    check("reset.ser4", ser4, 1);
    check("reset.done4", done4, 0);
    check("reset.ready8", ready8, 1);
    check("reset.ser8", ser8, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // 1101: spaced strobes, one held period, edge in IDLE ignored
    add(1, 0, 4'b1101, 0, 1, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 0);
    add(0, 0, 4'b0000, 0, 1, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 0, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 0);
`ifdef SERIAL_TX_PARITY_EN
    add(0, 1, 4'b0000, 0, 1, 1, 0);
`endif
    add(0, 1, 4'b0000, 0, 1, 1, 1);
    add(0, 1, 4'b0000, 1, 0, 1, 0);
    add(0, 1, 4'b0000, 1, 0, 1, 0);
    // Valid and strobe together in IDLE: the strobe is not a shifted bit
    add(1, 1, 4'b1101, 0, 1, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 0, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 0);
`ifdef SERIAL_TX_PARITY_EN
    add(0, 1, 4'b0000, 0, 1, 1, 0);
`endif
    add(0, 1, 4'b0000, 0, 1, 1, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 0);
    // 0110 offered during SHIFT waits until IDLE after txDone
    add(1, 0, 4'b1101, 0, 1, 1, 0);
    add(1, 1, 4'b0110, 0, 1, 1, 0);
    add(1, 1, 4'b0110, 0, 1, 0, 0);
    add(1, 1, 4'b0110, 0, 1, 1, 0);
`ifdef SERIAL_TX_PARITY_EN
    add(1, 1, 4'b0110, 0, 1, 1, 0);
`endif
    add(1, 1, 4'b0110, 0, 1, 1, 1);
    add(1, 1, 4'b0110, 1, 0, 1, 0);
    add(1, 1, 4'b0110, 0, 1, 0, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 1, 0);
    add(0, 1, 4'b0000, 0, 1, 0, 0);
`ifdef SERIAL_TX_PARITY_EN
    add(0, 1, 4'b0000, 0, 1, 0, 0);
`endif
    add(0, 1, 4'b0000, 0, 1, 1, 1);
    add(0, 0, 4'b0000, 1, 0, 1, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      dv4 = vecs[i].dv; pe4 = vecs[i].pe; word4 = vecs[i].word;
      @(negedge clk);
      check($sformatf("vec%0d.ready", i), ready4, vecs[i].ready);
      check($sformatf("vec%0d.busy", i), busy4, vecs[i].busy);
      check($sformatf("vec%0d.ser", i), ser4, vecs[i].ser);
      check($sformatf("vec%0d.done", i), done4, vecs[i].done);
    end

    // Reset mid-frame after two strobes
    dv4 = 1; word4 = 4'b1101; pe4 = 0;
    @(negedge clk);
    dv4 = 0; pe4 = 1;
    @(negedge clk);
    @(negedge clk);
    pe4 = 0;
    check("midreset.busy_before", busy4, 1);
    check("midreset.ser_before", ser4, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midreset.ser", ser4, 1);
    check("midreset.busy", busy4, 0);
    check("midreset.ready", ready4, 1);
    check("midreset.done", done4, 0);
    @(negedge clk);
    reset_n = 1'b1;
    pe4 = 1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 !== 1'b0) done_seen++;
    end
    pe4 = 0;
    check("midreset.no_done_after", done_seen, 0);

    // 0xA5 with a strobe on every clk
    exp_a5 = 8'hA5;
    dv8 = 1; word8 = 8'hA5; pe8 = 1;
    @(negedge clk);
    dv8 = 0;
    check("a5.bit0", ser8, exp_a5[7]);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("a5.bit%0d", k), ser8, exp_a5[7-k]);
      check($sformatf("a5.nodone%0d", k), done8, 0);
    end
    @(negedge clk);
`ifdef SERIAL_TX_PARITY_EN
    check("a5.parity", ser8, ^exp_a5);
    @(negedge clk);
`endif
    check("a5.done", done8, 1);
    check("a5.done_ser", ser8, 1);
    @(negedge clk);
    pe8 = 0;
    check("a5.ready_after", ready8, 1);
    check("a5.done_after", done8, 0);

    // Randomized traffic on the 8-bit instance
    m_q.delete();
    m_done = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit accepted;
      accepted = 0;
      @(negedge clk);
      if (m_done) begin
        m_done = 0;
      end else if (m_q.size() > 0) begin
        if (pe8) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1;
        end
      end else if (dv8) begin
        for (int b = 7; b >= 0; b--) m_q.push_back(word8[b]);
`ifdef SERIAL_TX_PARITY_EN
        m_q.push_back(^word8);
`endif
        accepted = 1;
      end
      check($sformatf("rnd%0d.ready", cyc), ready8, (!m_done && m_q.size() == 0));
      check($sformatf("rnd%0d.busy", cyc), busy8, (m_done || m_q.size() > 0));
      check($sformatf("rnd%0d.done", cyc), done8, m_done);
      check($sformatf("rnd%0d.ser", cyc), ser8, (m_q.size() > 0) ? m_q[0] : 1'b1);
      if (accepted) begin
        dv8 = ($urandom_range(1) == 1);
        word8 = 8'($urandom);
      end else if (!dv8 && $urandom_range(3) == 0) begin
        dv8 = 1;
        word8 = 8'($urandom);
      end
      pe8 = ((cyc / 300) % 2 == 1) ? 1'b1 : ($urandom_range(2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
